fpmul_share_ctrl: RTL and testbench
===================================

Name: fpmul_share_ctrl

Overview:
Shares one combinational FP32 multiplier (the team's `multiplierunit`) between N_REQ requesters.
- Each requester has a per-requester valid/ready request channel.
- A round-robin arbiter grants one request at a time.
- The block registers the operands, registers the multiplier result, and returns it on a single response channel tagged with the requester id.
- Sits between the scalar issue logic and the FP datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), width of the response id

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request valid, one bit per requester
req_ready  out  N_REQ  one-hot grant/accept, per requester
req_a  in  N_REQ*32  operand A per requester; slice i is [32*i+31:32*i], IEEE-754 single
req_b  in  N_REQ*32  operand B per requester, same packing
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  32  IEEE-754 product
resp_id  out  ID_W  index of the requester that issued this result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous active-low. On reset, all outputs are 0, the state is IDLE and rr_ptr = 0.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - If req_valid != 0, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Assert req_ready[g] combinationally in this cycle only.
  - On the clock edge, latch op_a/op_b/id_r from slice g and go to MUL.
  - If req_valid == 0, stay in IDLE with req_ready = 0.
- MUL: register the multiplier output (plus special-case logic if enabled) into res_r; go to RESP. No request is accepted.
- RESP:
  - resp_valid = 1; resp_data = res_r; resp_id = id_r.
  - Hold all three stable until resp_ready is high at a clock edge.
  - On that handshake: rr_ptr <= (id_r + 1) mod N_REQ, then go to IDLE.
  - resp_valid may not be withdrawn while waiting.
- Latency: 2 cycles from accept edge to resp_valid. Minimum of 3 cycles per operation.
- req_ready is 0 outside IDLE. A requester must hold req_valid and operands until it sees req_ready.
- Single requester continuously valid: served every 3 cycles (with resp_ready = 1), and the pointer wraps past it back to itself.
- All requesters valid: grants go in order rr_ptr, rr_ptr+1, ..., with no starvation.
- A req_valid drop in the same cycle it would be granted: the grant is made only if valid is high in that cycle. Ready is combinational, so there is no stale grant.
- Reset mid-operation: the in-flight operation is discarded, with no response.

Optional Feature:
Macro FPMUL_SPECIAL_EN.
- Defined: in MUL, override the raw product as follows.
  - Either operand NaN (exp = FF, frac != 0) -> 0x7FC00000.
  - Inf × zero -> 0x7FC00000.
  - Inf × finite nonzero -> {sA^sB, 8'hFF, 23'h0}.
  - Zero × finite -> {sA^sB, 31'h0}.
- Undefined: the raw multiplier output is passed through unchanged.

Decomposition:
- Package fpmul_pkg:
  - typedef fp32_t (logic [31:0]);
  - enum state_t {IDLE, MUL, RESP};
  - constants FP_QNAN = 32'h7FC00000 and FP_INF_EXP = 8'hFF;
  - function is_nan/is_inf/is_zero (used only under FPMUL_SPECIAL_EN).
- One sub-module: fpmul_rr_pick, a combinational round-robin picker (req vector, ptr) -> (any, grant index).
- `multiplierunit` is instantiated once.

Test Plan:
1. Reset mid-op: rst_n low for 2 cycles while in MUL -> all outputs 0, IDLE, no response afterwards.
2. req 0 only: A = 0x40000000, B = 0x40400000 -> req_ready[0] for 1 cycle; 2 cycles later resp_valid = 1, resp_data = 0x40C00000, resp_id = 0.
3. All 4 valid, resp_ready = 1, distinct operands:
   - grant order 0,1,2,3,0, one response every 3 cycles;
   - req 2 with A = 0x3FC00000, B = 0xC0000000 returns resp_id = 2, resp_data = 0xC0400000.
4. Backpressure: resp_ready = 0 for 5 cycles in RESP -> resp_data/resp_id stable, req_ready = 0 throughout; accepted on the first resp_ready = 1.
5. FPMUL_SPECIAL_EN:
   - 0x7F800000 × 0x00000000 -> 0x7FC00000;
   - 0xFF800000 × 0x40000000 -> 0xFF800000;
   - 0x80000000 × 0x40400000 -> 0x80000000;
   - without the macro, raw multiplier output is checked against the reference model.

Source files
------------

// File: rtl/fpmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpmul_pkg : shared types, constants and FP32 classifiers for the multiplier |
// | sharing controller. The classifiers are used only under FPMUL_SPECIAL_EN.   |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fpmul_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam fp32_t      FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0] FP_INF_EXP = 8'hFF;

  function automatic logic is_nan(input fp32_t x);
    return (x[30:23] == FP_INF_EXP) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x[30:23] == FP_INF_EXP) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic is_zero(input fp32_t x);
    return x[30:0] == 31'h0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpmul_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpmul_rr_pick : combinational round-robin picker; returns the first set     |
// | request at or above the pointer, wrapping modulo N_REQ.                     |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module fpmul_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_any,
  output logic [ID_W-1:0]  o_idx
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N_REQ;
      if (i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = ID_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multiplierunit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multiplierunit : combinational FP32 multiplier, round-to-nearest-even.      |
// | Subnormal inputs/results flush to signed zero, Inf/overflow give signed Inf.|
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module multiplierunit
  import fpmul_pkg::*;
(
  input  fp32_t i_a,
  input  fp32_t i_b,
  output fp32_t o_p
);

  logic        w_sign;
  logic [47:0] w_prod;
  logic [47:0] w_norm;
  logic        w_guard;
  logic        w_sticky;
  logic        w_up;
  logic [24:0] w_round;
  logic [9:0]  w_exp_sum;
  logic [7:0]  w_exp;

  assign w_sign = i_a[31] ^ i_b[31];
  assign w_prod = {24'b0, 1'b1, i_a[22:0]} * {24'b0, 1'b1, i_b[22:0]};

  // Align the leading one to bit 47 so rounding always looks at the same bits.
  assign w_norm    = w_prod[47] ? w_prod : {w_prod[46:0], 1'b0};
  assign w_guard   = w_norm[23];
  assign w_sticky  = |w_norm[22:0];
  assign w_up      = w_guard & (w_sticky | w_norm[24]);
  assign w_round   = {1'b0, w_norm[47:24]} + {24'b0, w_up};

  // Biased exponent sum before removing one bias; 127 < sum < 382 is a normal result.
  assign w_exp_sum = {2'b0, i_a[30:23]} + {2'b0, i_b[30:23]}
                   + {9'b0, w_prod[47]} + {9'b0, w_round[24]};
  assign w_exp     = w_exp_sum[7:0] - 8'd127;

  always_comb begin
    o_p = {w_sign, w_exp, (w_round[24] ? w_round[23:1] : w_round[22:0])};
    if (i_a[30:23] == 8'h00 || i_b[30:23] == 8'h00 || w_exp_sum <= 10'd127) begin
      o_p = {w_sign, 31'h0};
    end else if (i_a[30:23] == 8'hFF || i_b[30:23] == 8'hFF || w_exp_sum >= 10'd382) begin
      o_p = {w_sign, 8'hFF, 23'h0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpmul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpmul_share_ctrl : shares one FP32 multiplier among N_REQ requesters with   |
// | round-robin arbitration. Define FPMUL_SPECIAL_EN for IEEE special cases.    |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module fpmul_share_ctrl
  import fpmul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [ID_W-1:0]   resp_id,
  output logic              busy
);

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  fp32_t           r_op_a;
  fp32_t           r_op_b;
  logic [ID_W-1:0] r_id;
  fp32_t           r_res;
  logic            r_resp_valid;
  logic            r_busy;

  logic            w_any;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_ptr_next;
  fp32_t           w_raw;
  fp32_t           w_res;
  fp32_t           w_a [N_REQ];
  fp32_t           w_b [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_a[i] = req_a[32*i +: 32];
    assign w_b[i] = req_b[32*i +: 32];
  end

  fpmul_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  multiplierunit u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_raw)
  );

  // Grant is combinational so a requester dropping valid never receives a stale accept.
  always_comb begin
    req_ready = '0;
    if (rst_n && r_state == IDLE && w_any) begin
      req_ready[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_res = w_raw;
`ifdef FPMUL_SPECIAL_EN
    if (is_nan(r_op_a) || is_nan(r_op_b)) begin
      w_res = FP_QNAN;
    end else if ((is_inf(r_op_a) && is_zero(r_op_b)) || (is_zero(r_op_a) && is_inf(r_op_b))) begin
      w_res = FP_QNAN;
    end else if (is_inf(r_op_a) || is_inf(r_op_b)) begin
      w_res = {r_op_a[31] ^ r_op_b[31], FP_INF_EXP, 23'h0};
    end else if (is_zero(r_op_a) || is_zero(r_op_b)) begin
      w_res = {r_op_a[31] ^ r_op_b[31], 31'h0};
    end
`endif
  end

  assign w_ptr_next = (int'(r_id) == N_REQ - 1) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_id         <= '0;
      r_res        <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a  <= w_a[w_idx];
            r_op_b  <= w_b[w_idx];
            r_id    <= w_idx;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_res        <= w_res;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_rr_ptr     <= w_ptr_next;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_res;
  assign resp_id    = r_id;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpmul_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpmul_share_ctrl : self-checking bench with a transaction-level model of |
// | arbitration and an arithmetic FP32 product reference.                       |
// | Revision            : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_fpmul_share_ctrl;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [1:0]      resp_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_valid;
  logic [31:0]  m_a [N];
  logic [31:0]  m_b [N];
  int           m_ptr;

  logic [31:0] d_obs;
  logic [1:0]  id_obs;

  always #5 clk = ~clk;

  fpmul_share_ctrl #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive();
    req_valid = m_valid;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = m_a[i];
      req_b[32*i +: 32] = m_b[i];
    end
  endtask

  // Round-robin rule: first valid requester at or after the pointer.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(64, 190));
    return v;
  endfunction

  // Exact product of significands, rounded to nearest-even into 24 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    logic [63:0] ma, mb, p, q, r, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FPMUL_SPECIAL_EN
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if ((ea == 255 && b[30:0] == 0) || (eb == 255 && a[30:0] == 0)) return 32'h7FC00000;
`endif
    if (ea == 0 || eb == 0) return {s, 31'h0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    ma = {40'b0, 1'b1, a[22:0]};
    mb = {40'b0, 1'b1, b[22:0]};
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    q  = p >> sh;
    r  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic refresh(input int g);
    m_valid[g] = 1'($urandom_range(0, 1));
    m_a[g] = rand_norm();
    m_b[g] = rand_norm();
    if (m_valid == '0) m_valid[$urandom_range(0, N - 1)] = 1'b1;
  endtask

  // One full transaction from the IDLE cycle through the response handshake.
  task automatic serve(input int bp, input bit keep,
                       output logic [31:0] d_o, output logic [1:0] id_o);
    int g;
    logic [31:0] exp_d;
    drive();
    settle();
    g = pick();
    check("grant", {28'b0, req_ready}, 32'd1 << g);
    check("busy_idle", busy, 0);
    exp_d = ref_mul(m_a[g], m_b[g]);
    resp_ready = (bp == 0);
    tick();
    if (!keep) refresh(g);
    drive();
    settle();
    check("ready_mul", {28'b0, req_ready}, 0);
    check("valid_mul", resp_valid, 0);
    check("busy_mul", busy, 1);
    tick();
    settle();
    d_o  = resp_data;
    id_o = resp_id;
    for (int k = 0; k < bp; k++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, exp_d);
      check("bp_id", resp_id, g);
      check("bp_ready", {28'b0, req_ready}, 0);
      tick();
      settle();
    end
    check("resp_valid", resp_valid, 1);
    check("resp_data", resp_data, exp_d);
    check("resp_id", resp_id, g);
    check("resp_busy", busy, 1);
    resp_ready = 1'b1;
    tick();
    check("post_valid", resp_valid, 0);
    check("post_busy", busy, 0);
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    m_valid = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    drive();
    resp_ready = 1'b0;
    rst_n = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    check("rst_ready", {28'b0, req_ready}, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", resp_data, 0);
    check("rst_id", resp_id, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single requester 0: 2.0 * 3.0
    m_valid = 4'b0001;
    m_a[0] = 32'h40000000;
    m_b[0] = 32'h40400000;
    serve(0, 1'b1, d_obs, id_obs);
    check("t2_data", d_obs, 32'h40C00000);
    check("t2_id", id_obs, 0);
    m_valid = '0;

    // Reset while in MUL: operation is dropped and the pointer returns to 0.
    m_valid = 4'b0010;
    m_a[1] = 32'h40000000;
    m_b[1] = 32'h40000000;
    drive();
    settle();
    check("t1_grant", {28'b0, req_ready}, 32'h2);
    tick();
    check("t1_busy", busy, 1);
    m_valid = '0;
    drive();
    rst_n = 1'b0;
    settle();
    check("t1_rst_valid", resp_valid, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_data", resp_data, 0);
    check("t1_rst_id", resp_id, 0);
    check("t1_rst_ready", {28'b0, req_ready}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (4) begin
      tick();
      check("t1_no_resp", resp_valid, 0);
      check("t1_idle", busy, 0);
    end

    // All requesters valid: strict rotation starting at 0.
    m_valid = 4'hF;
    m_a[0] = 32'h3F800000; m_b[0] = 32'h40000000;
    m_a[1] = 32'h40000000; m_b[1] = 32'h40800000;
    m_a[2] = 32'h3FC00000; m_b[2] = 32'hC0000000;
    m_a[3] = 32'h40400000; m_b[3] = 32'h40A00000;
    for (int i = 0; i < 5; i++) begin
      serve(0, 1'b1, d_obs, id_obs);
      check("t3_order", id_obs, i % 4);
      if (i == 2) check("t3_req2", d_obs, 32'hC0400000);
    end

    // Backpressure for 5 cycles.
    serve(5, 1'b1, d_obs, id_obs);
    check("t4_id", id_obs, 1);
    check("t4_data", d_obs, 32'h41000000);

    // Lone requester 3 continuously valid: pointer wraps back to it.
    m_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      serve(0, 1'b1, d_obs, id_obs);
      check("single_id", id_obs, 3);
    end

    // Valid withdrawn before the edge: no grant is taken.
    m_valid = '0;
    drive();
    settle();
    check("none_ready", {28'b0, req_ready}, 0);
    tick();
    check("none_busy", busy, 0);
    m_valid = 4'b0100;
    drive();
    settle();
    check("drop_ready_on", {28'b0, req_ready}, 32'h4);
    m_valid = '0;
    drive();
    settle();
    check("drop_ready_off", {28'b0, req_ready}, 0);
    tick();
    settle();
    check("drop_busy", busy, 0);
    check("drop_valid", resp_valid, 0);

`ifdef FPMUL_SPECIAL_EN
    m_valid = 4'b0001;
    m_a[0] = 32'h7F800000; m_b[0] = 32'h00000000;
    serve(0, 1'b1, d_obs, id_obs);
    check("sp_inf_zero", d_obs, 32'h7FC00000);
    m_a[0] = 32'hFF800000; m_b[0] = 32'h40000000;
    serve(0, 1'b1, d_obs, id_obs);
    check("sp_inf_fin", d_obs, 32'hFF800000);
    m_a[0] = 32'h80000000; m_b[0] = 32'h40400000;
    serve(0, 1'b1, d_obs, id_obs);
    check("sp_zero_fin", d_obs, 32'h80000000);
`endif

    // Randomized traffic with random backpressure.
    m_valid = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++) begin
      m_a[i] = rand_norm();
      m_b[i] = rand_norm();
    end
    for (int n = 0; n < 40; n++) begin
      serve($urandom_range(0, 3), 1'b0, d_obs, id_obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
